branch_resolve_unit: RTL and testbench

Clocked branch-resolution unit for the PA-RISC pipeline: holds the architectural condition flags and evaluates BL and COMB/COMBF decisions against them. It also tracks a parametrised number of delay slots, applies PA-RISC `,n` nullification, and issues a single-cycle fetch redirect after the last delay slot. It sits between the execute-stage flag producer and the fetch/PC logic.

---
 rtl/branch_resolve_unit.sv | 122 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: PA-RISC flag register, BL/COMB decision, delay-slot tracking, nullification, fetch redirect.
// Optional macro BRU_FLAG_BYPASS_EN forwards flags_in to a branch accepted in the same cycle as the flag write.
`default_nettype none

module branch_resolve_unit #(
  parameter int DELAY_SLOTS = 1,
  parameter int TGT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             flags_we,
  input  logic [3:0]       flags_in,
  input  logic             br_valid,
  input  logic             br_uncond,
  input  logic             br_cond,
  input  logic             br_neg,
  input  logic [2:0]       cond,
  input  logic             nullify,
  input  logic             disp_neg,
  input  logic [TGT_W-1:0] br_target,
  output logic             taken_o,
  output logic             redirect_valid,
  output logic [TGT_W-1:0] redirect_target,
  output logic             nullify_slot,
  output logic             busy,
  output logic             dslot_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT  = 2'd1,
    REDIR = 2'd2
  } state_t;

  localparam logic [2:0] SLOTS_INIT = 3'(DELAY_SLOTS);

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [3:0] flags_q, flags_eff;
  logic       taken_q, null_q;
  logic       cond_true, taken_d, null_d, accept;

`ifdef BRU_FLAG_BYPASS_EN
  assign flags_eff = flags_we ? flags_in : flags_q;
`else
  assign flags_eff = flags_q;
`endif

  // flags_eff = {Z, N, C, V}
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'd0: cond_true = 1'b0;
      3'd1: cond_true = flags_eff[3];
      3'd2: cond_true = flags_eff[2] ^ flags_eff[0];
      3'd3: cond_true = (flags_eff[2] ^ flags_eff[0]) | flags_eff[3];
      3'd4: cond_true = flags_eff[1];
      3'd5: cond_true = flags_eff[1] | flags_eff[3];
      3'd6: cond_true = flags_eff[0];
      3'd7: cond_true = ~flags_eff[3];
      default: cond_true = 1'b0;
    endcase
  end

  // Forward conditional branches nullify when taken, backward ones when not taken.
  assign taken_d = br_uncond | (br_cond & (cond_true ^ br_neg));
  assign null_d  = nullify & (br_uncond | (br_cond & (disp_neg ? ~taken_d : taken_d)));
  assign accept  = br_valid & adv & (state == IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SLOT;
          cnt_n   = SLOTS_INIT;
        end
      end
      SLOT: begin
        if (adv) begin
          cnt_n = cnt - 3'd1;
          if (cnt == 3'd1) state_n = taken_q ? REDIR : IDLE;
        end
      end
      REDIR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 3'd0;
      flags_q         <= 4'b0000;
      taken_q         <= 1'b0;
      null_q          <= 1'b0;
      taken_o         <= 1'b0;
      redirect_target <= '0;
      dslot_err       <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      taken_o <= accept & taken_d;
      if (flags_we) flags_q <= flags_in;
      if (accept) begin
        taken_q         <= taken_d;
        null_q          <= null_d;
        redirect_target <= br_target;
      end
      if ((state == SLOT) && br_valid && !null_q) dslot_err <= 1'b1;
    end
  end

  assign redirect_valid = (state == REDIR);
  assign nullify_slot   = (state == SLOT) & null_q;
  assign busy           = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench: three instances (DELAY_SLOTS = 1, 2, 3) share one stimulus stream.
`default_nettype none

module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n, adv, flags_we, br_valid, br_uncond, br_cond, br_neg, nullify, disp_neg;
  logic [3:0]  flags_in;
  logic [2:0]  cond;
  logic [31:0] br_target;

  logic        tk1, rv1, ns1, bz1, de1;
  logic        tk2, rv2, ns2, bz2, de2;
  logic        tk3, rv3, ns3, bz3, de3;
  logic [31:0] rt1, rt2, rt3;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_bypass;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DELAY_SLOTS(1), .TGT_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .adv(adv), .flags_we(flags_we), .flags_in(flags_in),
    .br_valid(br_valid), .br_uncond(br_uncond), .br_cond(br_cond), .br_neg(br_neg),
    .cond(cond), .nullify(nullify), .disp_neg(disp_neg), .br_target(br_target),
    .taken_o(tk1), .redirect_valid(rv1), .redirect_target(rt1), .nullify_slot(ns1),
    .busy(bz1), .dslot_err(de1));

  branch_resolve_unit #(.DELAY_SLOTS(2), .TGT_W(32)) u2 (
    .clk(clk), .rst_n(rst_n), .adv(adv), .flags_we(flags_we), .flags_in(flags_in),
    .br_valid(br_valid), .br_uncond(br_uncond), .br_cond(br_cond), .br_neg(br_neg),
    .cond(cond), .nullify(nullify), .disp_neg(disp_neg), .br_target(br_target),
    .taken_o(tk2), .redirect_valid(rv2), .redirect_target(rt2), .nullify_slot(ns2),
    .busy(bz2), .dslot_err(de2));

  branch_resolve_unit #(.DELAY_SLOTS(3), .TGT_W(32)) u3 (
    .clk(clk), .rst_n(rst_n), .adv(adv), .flags_we(flags_we), .flags_in(flags_in),
    .br_valid(br_valid), .br_uncond(br_uncond), .br_cond(br_cond), .br_neg(br_neg),
    .cond(cond), .nullify(nullify), .disp_neg(disp_neg), .br_target(br_target),
    .taken_o(tk3), .redirect_valid(rv3), .redirect_target(rt3), .nullify_slot(ns3),
    .busy(bz3), .dslot_err(de3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_br();
    br_valid = 0; br_uncond = 0; br_cond = 0; br_neg = 0;
    cond = 3'd0; nullify = 0; disp_neg = 0;
  endtask

  initial begin
    rst_n = 0; adv = 1; flags_we = 0; flags_in = 4'b0000; br_target = 32'h0;
    clear_br();
    tick();
    check("rst_taken",  {31'd0, tk1}, 32'd0);
    check("rst_redir",  {31'd0, rv1}, 32'd0);
    check("rst_target", rt1, 32'd0);
    check("rst_null",   {31'd0, ns1}, 32'd0);
    check("rst_busy",   {31'd0, bz1}, 32'd0);
    check("rst_err",    {31'd0, de1}, 32'd0);
    rst_n = 1;
    tick();

    // COMB on Z, taken, DELAY_SLOTS=1
    flags_we = 1; flags_in = 4'b1000;
    tick();
    flags_we = 0;
    br_valid = 1; br_cond = 1; cond = 3'd1; br_target = 32'h0000_1000;
    tick();
    clear_br();
    check("t1_taken",   {31'd0, tk1}, 32'd1);
    check("t1_busy",    {31'd0, bz1}, 32'd1);
    check("t1_null_s",  {31'd0, ns1}, 32'd0);
    check("t1_noredir", {31'd0, rv1}, 32'd0);
    tick();
    check("t1_redir",   {31'd0, rv1}, 32'd1);
    check("t1_target",  rt1, 32'h0000_1000);
    check("t1_tk_off",  {31'd0, tk1}, 32'd0);
    check("t1_null_r",  {31'd0, ns1}, 32'd0);
    tick();
    check("t1_redir_off", {31'd0, rv1}, 32'd0);
    check("t1_idle",      {31'd0, bz1}, 32'd0);
    check("t1_d2_redir",  {31'd0, rv2}, 32'd1);
    repeat (3) tick();

    // N=1, cond N^V, br_neg=1 -> not taken
    flags_we = 1; flags_in = 4'b0100;
    tick();
    flags_we = 0;
    br_valid = 1; br_cond = 1; cond = 3'd2; br_neg = 1; br_target = 32'h0000_2000;
    tick();
    clear_br();
    check("t2_taken", {31'd0, tk1}, 32'd0);
    check("t2_busy",  {31'd0, bz1}, 32'd1);
    tick();
    check("t2_idle",  {31'd0, bz1}, 32'd0);
    check("t2_redir", {31'd0, rv1}, 32'd0);
    repeat (3) tick();

    // backward COMB ,n with false condition, DELAY_SLOTS=2: slots nullified, no redirect
    br_valid = 1; br_cond = 1; cond = 3'd0; nullify = 1; disp_neg = 1; br_target = 32'h0000_3000;
    tick();
    clear_br();
    for (int i = 0; i < 2; i++) begin
      check("t3_null", {31'd0, ns2}, 32'd1);
      check("t3_redir", {31'd0, rv2}, 32'd0);
      tick();
    end
    check("t3_null_off", {31'd0, ns2}, 32'd0);
    check("t3_idle",     {31'd0, bz2}, 32'd0);
    check("t3_noredir",  {31'd0, rv2}, 32'd0);
    repeat (3) tick();

    // BL ,n with DELAY_SLOTS=3 and two stalled slot cycles
    br_valid = 1; br_uncond = 1; nullify = 1; br_target = 32'hABCD_0000;
    tick();
    clear_br();
    check("t4_taken", {31'd0, tk3}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) adv = 0;
      if (i == 3) adv = 1;
      check("t4_null", {31'd0, ns3}, 32'd1);
      check("t4_redir_early", {31'd0, rv3}, 32'd0);
      tick();
    end
    check("t4_redir",    {31'd0, rv3}, 32'd1);
    check("t4_target",   rt3, 32'hABCD_0000);
    check("t4_null_off", {31'd0, ns3}, 32'd0);
    repeat (3) tick();

    // branch in an unnullified delay slot sets the sticky error
    br_valid = 1; br_uncond = 1; br_target = 32'h0000_5000;
    tick();
    check("t5_err_pre", {31'd0, de2}, 32'd0);
    tick();
    clear_br();
    check("t5_err",  {31'd0, de2}, 32'd1);
    check("t5_busy", {31'd0, bz2}, 32'd1);
    repeat (4) tick();
    check("t5_err_sticky", {31'd0, de2}, 32'd1);

    // asynchronous reset mid-SLOT
    br_valid = 1; br_uncond = 1; br_target = 32'h0000_6000;
    tick();
    clear_br();
    check("t5_slot_busy", {31'd0, bz3}, 32'd1);
    rst_n = 0;
    #1;
    check("arst_busy",   {31'd0, bz3}, 32'd0);
    check("arst_taken",  {31'd0, tk3}, 32'd0);
    check("arst_err",    {31'd0, de2}, 32'd0);
    check("arst_target", rt3, 32'd0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      check("arst_noredir", {29'd0, rv1, rv2, rv3}, 32'd0);
      tick();
    end

    // branch arriving while u1 is in REDIR is flushed without error
    br_valid = 1; br_uncond = 1; br_target = 32'h0000_7000;
    tick();
    clear_br();
    tick();
    check("t6_redir", {31'd0, rv1}, 32'd1);
    br_valid = 1; br_uncond = 1; br_target = 32'h0000_7777;
    tick();
    clear_br();
    check("t6_no_err",    {31'd0, de1}, 32'd0);
    check("t6_no_accept", {31'd0, bz1}, 32'd0);
    check("t6_target",    rt1, 32'h0000_7000);
    repeat (4) tick();

    // flag write coinciding with accept; flags_q currently has Z=0
    flags_we = 1; flags_in = 4'b0000;
    tick();
`ifdef BRU_FLAG_BYPASS_EN
    exp_bypass = 1'b1;
`else
    exp_bypass = 1'b0;
`endif
    flags_in = 4'b1000;
    br_valid = 1; br_cond = 1; cond = 3'd1; br_target = 32'h0000_8000;
    tick();
    flags_we = 0;
    clear_br();
    check("t7_taken", {31'd0, tk1}, {31'd0, exp_bypass});
    tick();
    check("t7_redir", {31'd0, rv1}, {31'd0, exp_bypass});
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
